// File: rtl/cpu_axi_pkg.sv
// Shared types and fixed AXI field values for the CPU-to-AXI bridge.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    RD_RESP,
    WR_REQ,
    WR_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         ID_INST    = 0;
  localparam int         ID_DATA    = 1;

endpackage

// File: rtl/cpu_axi_arb.sv
// Two-way arbiter between the fetch port and the data port.
// Build option: define DATA_PRIO_EN for fixed priority (data port always
// wins ties); leave it undefined for round-robin driven by a last-grant bit.
// grant is one-hot: bit 0 = fetch, bit 1 = data; all-zero when nobody asks.
module cpu_axi_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_inst,
  input  logic       req_data,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef DATA_PRIO_EN

  // fixed priority: data first, fetch only when data is quiet
  always_comb begin
    grant = 2'b00;
    if (req_data)      grant = 2'b10;
    else if (req_inst) grant = 2'b01;
  end

  logic unused_arb;
  assign unused_arb = &{1'b0, clk, rst, advance};

`else

  // 1 = data port was granted last; reset value hands the first tie to fetch
  logic last_grant;

  // remember which port took the most recent grant
  always_ff @(posedge clk) begin
    if (rst)          last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  end

  // round-robin: on a tie the port not granted last wins
  always_comb begin
    grant = 2'b00;
    if (req_inst && req_data) grant = last_grant ? 2'b01 : 2'b10;
    else if (req_inst)        grant = 2'b01;
    else if (req_data)        grant = 2'b10;
  end

`endif

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU fetch and load/store ports onto one AXI4 master port.
// One single-beat transaction in flight at a time; every AXI channel may
// stall arbitrarily. Arbitration policy is selected in cpu_axi_arb by the
// DATA_PRIO_EN build macro.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // fetch port
  input  logic                    inst_req_valid,
  output logic                    inst_req_ready,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [DATA_WIDTH-1:0]   instruction,
  // data port
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    read_data_valid,
  input  logic                    read_data_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  // AXI read address
  output logic [ID_WIDTH-1:0]     axi_arid,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arlock,
  output logic [3:0]              axi_arcache,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]     axi_rid,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  // AXI write address
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awlock,
  output logic [3:0]              axi_awcache,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_t                state, state_nx;
  logic                  is_data_q, is_write_q;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            grant;
  logic                  req_data, arb_en, take;
  logic [ID_WIDTH-1:0]   id_issued;

  assign req_data = mem_read | mem_write;
  assign arb_en   = (state == IDLE) && !rst;
  assign take     = arb_en && (inst_req_valid || req_data);

  cpu_axi_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_inst (inst_req_valid),
    .req_data (req_data),
    .advance  (take),
    .grant    (grant)
  );

  // all AXI payloads come straight from registers latched at grant time
  assign id_issued   = is_data_q ? ID_WIDTH'(ID_DATA) : ID_WIDTH'(ID_INST);
  assign axi_arid    = id_issued;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = SIZE_4B;
  assign axi_arburst = BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'd0;
  assign axi_arprot  = 3'd0;
  assign axi_awid    = ID_WIDTH'(ID_DATA);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = SIZE_4B;
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'd0;
  assign axi_awprot  = 3'd0;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign instruction = rdata_q;
  assign read_data   = rdata_q;

  // response status and last flags carry nothing this bridge acts on
  logic unused_resp;
  assign unused_resp = &{1'b0, axi_rresp == RESP_OKAY, axi_rlast, axi_bresp, axi_bid, is_write_q};

  // next state plus every handshake output, decoded from the current state
  always_comb begin
    state_nx        = state;
    inst_req_ready  = 1'b0;
    mem_req_ready   = 1'b0;
    inst_valid      = 1'b0;
    read_data_valid = 1'b0;
    axi_arvalid     = 1'b0;
    axi_rready      = 1'b0;
    axi_awvalid     = 1'b0;
    axi_wvalid      = 1'b0;
    axi_bready      = 1'b0;
    unique case (state)
      IDLE: begin
        inst_req_ready = arb_en & grant[0];
        mem_req_ready  = arb_en & grant[1];
        if (inst_req_ready)     state_nx = RD_ADDR;
        else if (mem_req_ready) state_nx = mem_write ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_nx = RD_RESP;
      end
      RD_RESP: begin
        inst_valid      = !is_data_q;
        read_data_valid = is_data_q;
        if (is_data_q ? read_data_ready : inst_ready) state_nx = IDLE;
      end
      WR_REQ: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        // a channel already done counts as complete; otherwise its ready completes it now
        if ((aw_done || axi_awready) && (w_done || axi_wready)) state_nx = WR_RESP;
      end
      WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register and per-channel write completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == WR_REQ && state_nx == WR_REQ) begin
        if (axi_awvalid && axi_awready) aw_done <= 1'b1;
        if (axi_wvalid && axi_wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // transaction kind, captured on grant
  always_ff @(posedge clk) begin
    if (rst) begin
      is_data_q  <= 1'b0;
      is_write_q <= 1'b0;
    end else if (take) begin
      is_data_q  <= grant[1];
      is_write_q <= grant[1] & mem_write;
    end
  end

  // request payload, captured on grant
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= grant[1] ? address : pc;
      wdata_q <= write_data;
      wstrb_q <= write_strb;
    end
  end

  // response register: loaded on the R handshake, frozen while the CPU stalls
  always_ff @(posedge clk) begin
    if (rst)                             rdata_q <= '0;
    else if (state == RD_DATA && axi_rvalid) rdata_q <= axi_rdata;
  end

  // simulation-only sanity checks on illegal CPU requests and stray read IDs
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_read && mem_write))
        else $error("cpu_axi_bridge: mem_read and mem_write asserted together, write served");
      if (state == RD_DATA && axi_rvalid)
        assert (axi_rid == id_issued)
          else $error("cpu_axi_bridge: rid does not match the issued ID");
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Randomized bench for cpu_axi_bridge with a stalling AXI RAM and a reference
// memory model. Define DATA_PRIO_EN when building for the fixed-priority variant.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req_valid = 1'b0, inst_req_ready;
  logic [31:0] pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] instruction;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_req_ready;
  logic [31:0] address = '0, write_data = '0;
  logic [3:0]  write_strb = '0;
  logic        read_data_valid, read_data_ready = 1'b0;
  logic [31:0] read_data;
  logic [3:0]  axi_arid, axi_awid, axi_rid, axi_bid;
  logic [31:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic        axi_arlock, axi_awlock, axi_rlast, axi_wlast;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .mem_read(mem_read), .mem_write(mem_write), .mem_req_ready(mem_req_ready),
    .address(address), .write_data(write_data), .write_strb(write_strb),
    .read_data_valid(read_data_valid), .read_data_ready(read_data_ready), .read_data(read_data),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // reference memory: what the CPU should observe, updated at each store grant
  logic [31:0] ref_mem [256];
  int gq[$];

  // ---------------- AXI RAM with random handshake masking ----------------
  logic [31:0] ram [256];
  bit          stall_en = 1'b0;
  bit          r_hold = 1'b0;
  logic        rd_pend, got_aw, got_w;
  logic [31:0] rd_a, wa, wd;
  logic [3:0]  rd_i, ws, wid;

  assign axi_rresp = 2'b00;
  assign axi_rlast = 1'b1;
  assign axi_bresp = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      axi_arready <= 1'b0; axi_rvalid <= 1'b0; axi_awready <= 1'b0;
      axi_wready <= 1'b0; axi_bvalid <= 1'b0; rd_pend <= 1'b0;
      got_aw <= 1'b0; got_w <= 1'b0; axi_rdata <= '0; axi_rid <= '0; axi_bid <= '0;
    end else begin
      axi_arready <= !stall_en || ($urandom_range(0, 2) != 0);
      axi_awready <= !stall_en || ($urandom_range(0, 2) != 0);
      axi_wready  <= !stall_en || ($urandom_range(0, 2) != 0);
      if (axi_arvalid && axi_arready) begin
        if (!r_hold && (!stall_en || $urandom_range(0, 1) == 1)) begin
          axi_rvalid <= 1'b1; axi_rdata <= ram[axi_araddr[9:2]]; axi_rid <= axi_arid;
        end else begin
          rd_pend <= 1'b1; rd_a <= axi_araddr; rd_i <= axi_arid;
        end
      end
      if (rd_pend && !r_hold && (!stall_en || $urandom_range(0, 1) == 1)) begin
        axi_rvalid <= 1'b1; axi_rdata <= ram[rd_a[9:2]]; axi_rid <= rd_i; rd_pend <= 1'b0;
      end
      if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
      if (axi_awvalid && axi_awready) begin got_aw <= 1'b1; wa <= axi_awaddr; wid <= axi_awid; end
      if (axi_wvalid && axi_wready) begin got_w <= 1'b1; wd <= axi_wdata; ws <= axi_wstrb; end
      if (got_aw && got_w && !axi_bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
        ram[wa[9:2]] <= merge_bytes(ram[wa[9:2]], wd, ws);
        axi_bvalid <= 1'b1; axi_bid <= wid; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
    end
  end

  // ---------------- AXI master-side stability monitor ----------------
  logic        ar_st, aw_st, w_st;
  logic [35:0] ar_p, aw_p, w_p;

  always @(posedge clk) begin
    if (rst) begin
      ar_st <= 1'b0; aw_st <= 1'b0; w_st <= 1'b0;
    end else begin
      if (ar_st) chk("ar_hold", {axi_arvalid, axi_araddr, axi_arid}, {1'b1, ar_p});
      if (aw_st) chk("aw_hold", {axi_awvalid, axi_awaddr, axi_awid}, {1'b1, aw_p});
      if (w_st)  chk("w_hold",  {axi_wvalid, axi_wdata, axi_wstrb},  {1'b1, w_p});
      ar_st <= axi_arvalid && !axi_arready; ar_p <= {axi_araddr, axi_arid};
      aw_st <= axi_awvalid && !axi_awready; aw_p <= {axi_awaddr, axi_awid};
      w_st  <= axi_wvalid && !axi_wready;   w_p  <= {axi_wdata, axi_wstrb};
    end
  end

  // ---------------- CPU-side drivers ----------------
  task automatic fetch(input logic [31:0] a, input int stall, input int want_lat, input bit dir);
    bit hs; int n; logic [31:0] exp;
    pc = a; inst_req_valid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 1000) begin #1; hs = inst_req_ready; @(negedge clk); n++; end
    inst_req_valid = 1'b0;
    chk("fetch_grant", hs, 1);
    if (!hs) return;
    gq.push_back(0);
    exp = ref_mem[a[9:2]];
    if (dir) begin
      chk("ar_first", {axi_arvalid, axi_araddr, axi_arid}, {1'b1, a, 4'd0});
      chk("ar_fixed", {axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot},
          {8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0});
    end
    #1; n = 1;
    while (!inst_valid && n < 1000) begin @(negedge clk); #1; n++; end
    chk("fetch_valid", inst_valid, 1);
    if (want_lat >= 0) chk("fetch_latency", n, want_lat);
    chk("fetch_data", instruction, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      chk("fetch_hold", {inst_valid, instruction}, {1'b1, exp});
      chk("fetch_no_ar", axi_arvalid, 0);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic data_op(input bit wr, input logic [31:0] a, input logic [31:0] wdat,
                         input logic [3:0] s, input int stall, input bit dir);
    bit hs; int n; logic [31:0] exp;
    address = a; write_data = wdat; write_strb = s;
    mem_write = wr; mem_read = !wr; hs = 1'b0; n = 0;
    while (!hs && n < 1000) begin #1; hs = mem_req_ready; @(negedge clk); n++; end
    mem_write = 1'b0; mem_read = 1'b0;
    chk(wr ? "store_grant" : "load_grant", hs, 1);
    if (!hs) return;
    gq.push_back(1);
    if (wr) begin
      ref_mem[a[9:2]] = merge_bytes(ref_mem[a[9:2]], wdat, s);
      if (dir) begin
        chk("aw_w_same_cycle", {axi_awvalid, axi_wvalid}, 2'b11);
        chk("aw_payload", {axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst},
            {a, 4'd1, 8'd0, 3'b010, 2'b01});
        chk("w_payload", {axi_wdata, axi_wstrb, axi_wlast}, {wdat, s, 1'b1});
      end
      return;
    end
    exp = ref_mem[a[9:2]];
    if (dir) chk("ar_data_id", {axi_arvalid, axi_araddr, axi_arid}, {1'b1, a, 4'd1});
    #1; n = 1;
    while (!read_data_valid && n < 1000) begin @(negedge clk); #1; n++; end
    chk("load_valid", read_data_valid, 1);
    chk("load_data", read_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      chk("load_hold", {read_data_valid, read_data}, {1'b1, exp});
      chk("load_no_ar", axi_arvalid, 0);
    end
    read_data_ready = 1'b1;
    @(negedge clk);
    read_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  localparam int RR_N = 6;

  initial begin
    bit hs; int n; int kind; logic [31:0] a;
    for (int i = 0; i < 256; i++) begin ram[i] = init_word(i); ref_mem[i] = init_word(i); end
    ram[8'h40] = 32'h0000_0013; ref_mem[8'h40] = 32'h0000_0013;

    repeat (3) @(negedge clk);
    chk("reset_handshakes", {inst_req_ready, mem_req_ready, inst_valid, read_data_valid, axi_arvalid,
        axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 9'h0);
    chk("reset_resp_data", {instruction, read_data}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // zero-stall fetch: latency and AR fields
    fetch(32'h100, 0, 3, 1'b1);

    // partial store over a cleared word, then read back
    data_op(1'b1, 32'h40, 32'h0000_0000, 4'hF, 0, 1'b0);
    data_op(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 0, 1'b1);
    data_op(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b1);
    chk("store_merge", ref_mem[8'h10], 32'h0000_BEEF);

    // consumer holds inst_ready low for 5 cycles
    fetch(32'h100, 5, 3, 1'b0);

    // reset while waiting in the read-data phase
    r_hold = 1'b1;
    pc = 32'h80; inst_req_valid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 100) begin #1; hs = inst_req_ready; @(negedge clk); n++; end
    inst_req_valid = 1'b0;
    n = 0;
    while (!axi_rready && n < 100) begin @(negedge clk); n++; end
    chk("reach_rd_data", axi_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_handshakes", {inst_req_ready, mem_req_ready, inst_valid, read_data_valid, axi_arvalid,
        axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 9'h0);
    chk("rst_mid_resp_data", {instruction, read_data}, 64'h0);
    rst = 1'b0; r_hold = 1'b0;
    @(negedge clk);
    fetch(32'h100, 0, 3, 1'b0);

    // both ports requesting back to back from a fresh reset
    do_reset();
    stall_en = 1'b1;
    gq.delete();
    fork
      begin
        for (int i = 0; i < RR_N; i++) fetch(32'($urandom_range(0, 255)) << 2, 0, -1, 1'b0);
      end
      begin
        for (int j = 0; j < RR_N; j++) data_op(1'b0, 32'($urandom_range(0, 255)) << 2, 32'h0, 4'h0, 0, 1'b0);
      end
    join
    chk("rr_count", gq.size(), 2 * RR_N);
    for (int i = 0; i < gq.size() && i < 2 * RR_N; i++) begin
`ifdef DATA_PRIO_EN
      chk("grant_order", gq[i], (i < RR_N) ? 1 : 0);
`else
      chk("grant_order", gq[i], i % 2);
`endif
    end

    // long random mix under random stalls on all channels
    for (int t = 0; t < 1500; t++) begin
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 255)) << 2;
      case (kind)
        0:       fetch(a, $urandom_range(0, 3), -1, 1'b0);
        1:       data_op(1'b0, a, 32'h0, 4'h0, $urandom_range(0, 3), 1'b0);
        default: data_op(1'b1, a, $urandom, 4'($urandom_range(1, 15)), 0, 1'b0);
      endcase
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
